// File: rtl/piso_dir_tx.sv
// Parallel-in serial-out transmitter with per-frame shift direction (MSB or LSB first).
// Build option PISO_PARITY_EN appends an even-parity bit after the data bits.
//
// state | meaning
// IDLE  | ready for a new word, serial outputs quiet
// SHIFT | presenting data bits, one per clock
// PAR   | presenting the parity bit (PISO_PARITY_EN only)

module piso_dir_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic par_q;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             dir_q;

    always_ff @(posedge clk) begin
        if (R) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg <= din;
                        dir_q <= dir;
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef PISO_PARITY_EN
                        par_q <= ^din;
`endif
                    end
                end
                SHIFT: begin
                    shreg <= dir_q ? (shreg >> 1) : (shreg << 1);
                    if (cnt == CNT_LAST) begin
                        // Wrap to zero so cnt stays in range for non-power-of-two widths.
                        cnt <= '0;
`ifdef PISO_PARITY_EN
                        state <= PAR;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef PISO_PARITY_EN
                PAR: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready = (state == IDLE);
        busy       = (state != IDLE);
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_last  = 1'b0;
        if (state == SHIFT) begin
            sout       = dir_q ? shreg[0] : shreg[WIDTH-1];
            sout_valid = 1'b1;
`ifndef PISO_PARITY_EN
            sout_last  = (cnt == CNT_LAST);
`endif
        end
`ifdef PISO_PARITY_EN
        if (state == PAR) begin
            sout       = par_q;
            sout_valid = 1'b1;
            sout_last  = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_piso_dir_tx.sv
// Self-checking bench for piso_dir_tx: vector table plus scoreboard of expected serial bits.
// Honours PISO_PARITY_EN by appending the expected parity bit to each frame.

module tb_piso_dir_tx;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         R;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] din;
    logic         dir;
    logic         sout;
    logic         sout_valid;
    logic         sout_last;
    logic         busy;
    logic         mon_en;

    int tests = 0;
    int fails = 0;

    // Each entry: {expected sout, expected sout_last}
    logic [1:0] sb[$];

    typedef struct {
        logic [W-1:0] din;
        logic         dir;
        logic [W-1:0] seq;   // transmission order, leftmost bit first
        logic         par;
        bit           hold;  // keep load_valid high and scramble din/dir mid-frame
    } vec_t;

    vec_t tbl[7];

    piso_dir_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .R          (R),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .din        (din),
        .dir        (dir),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [1:0] e;
        if (mon_en) begin
            if (sout_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_bit: got sout_valid=1 with no bit pending at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sout_bit", sout, e[1]);
                    chk("sout_last", sout_last, e[0]);
                end
            end else begin
                chk("idle_sout_last", {sout, sout_last}, 2'b00);
            end
        end
    end

    task automatic push_frame(input vec_t v);
        logic b;
        for (int k = 0; k < FL; k++) begin
            b = (k < W) ? v.seq[W-1-k] : v.par;
            sb.push_back({b, (k == FL - 1)});
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the idle cycle after the frame.
    task automatic do_frame(input vec_t v);
        int n;
        chk("ready_before_load", load_ready, 1);
        load_valid = 1'b1;
        din        = v.din;
        dir        = v.dir;
        push_frame(v);
        @(negedge clk);
        chk("first_bit_valid", sout_valid, 1);
        n = 0;
        while (busy === 1'b1 && n < FL + 4) begin
            if (v.hold) begin
                din = W'($urandom);
                dir = ~dir;
            end else begin
                load_valid = 1'b0;
                din        = ~v.din;
                dir        = ~v.dir;
            end
            @(negedge clk);
            n++;
        end
        chk("frame_len", n, FL);
        chk("gap_idle", {sout_valid, load_ready}, 2'b01);
        load_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'b1011, 1'b0, 4'b1011, 1'b1, 1'b0};
        tbl[1] = '{4'b1011, 1'b1, 4'b1101, 1'b1, 1'b0};
        tbl[2] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1};
        tbl[3] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1};
        tbl[4] = '{4'b0101, 1'b0, 4'b0101, 1'b0, 1'b0};
        tbl[5] = '{4'b0110, 1'b1, 4'b0110, 1'b0, 1'b0};
        tbl[6] = '{4'b0011, 1'b0, 4'b0011, 1'b0, 1'b0};

        R          = 1'b1;
        load_valid = 1'b0;
        din        = '0;
        dir        = 1'b0;
        mon_en     = 1'b0;
        repeat (2) @(negedge clk);
        R = 1'b0;
        chk("rst_load_ready", load_ready, 1);
        chk("rst_sout", sout, 0);
        chk("rst_sout_valid", sout_valid, 0);
        chk("rst_sout_last", sout_last, 0);
        chk("rst_busy", busy, 0);

        // Reset wins over a simultaneous load request.
        R          = 1'b1;
        load_valid = 1'b1;
        din        = 4'b1111;
        @(negedge clk);
        chk("rst_priority_busy", busy, 0);
        chk("rst_priority_ready", load_ready, 1);
        R          = 1'b0;
        load_valid = 1'b0;
        mon_en     = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) do_frame(tbl[i]);

        // Abort a frame during its second bit.
        chk("ready_before_abort", load_ready, 1);
        load_valid = 1'b1;
        din        = 4'b1111;
        dir        = 1'b0;
        sb.push_back(2'b10);
        sb.push_back(2'b10);
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        chk("abort_sout_valid", sout_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_load_ready", load_ready, 1);
        chk("abort_pending", sb.size(), 0);
        R = 1'b0;

        for (int i = 4; i < 7; i++) do_frame(tbl[i]);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
